// File: rtl/atoier_if.sv
// Byte-wide memory bus between a master and an 8-bit single-port RAM.
interface mb8_io #(
    parameter int unsigned ASZ = 17
);
    logic [ASZ-1:0] ai;   // byte address
    logic           we;   // write enable
    logic [7:0]     vi;   // write data
    logic [7:0]     vo;   // read data

    modport master (output ai, output we, output vi, input vo);
    modport slave  (input ai, input we, input vi, output vo);
endinterface

// File: rtl/atoier.sv
// ASCII-to-integer converter: walks a NUL-terminated decimal/hex string in
// byte memory and produces a signed DSZ-bit two's-complement value.
module atoier #(
    parameter int unsigned ASZ = 17,
    parameter int unsigned DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           hex,
    input  logic [ASZ-1:0] tib,
    input  logic [7:0]     ch,
    mb8_io.master          mb_if,
    output logic           bsy,
    output logic [DSZ-1:0] vo
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIGW = 4;

    state_t         state_q, state_d;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [DSZ-1:0] acc_q, acc_d;
    logic [DSZ-1:0] vo_q, vo_d;
    logic           neg_q, neg_d;
    logic           hex_q, hex_d;
    logic           term_q, term_d;   // first character was already a terminator
    logic           bsy_q, bsy_d;

    logic            dig_ok;
    logic [DIGW-1:0] dig_val;
    logic [DSZ-1:0]  acc_mul;

    // Returns {valid, value} for one character in the selected base.
    function automatic logic [DIGW:0] decode(input logic [7:0] c, input logic hm);
        logic [DIGW:0] r;
        r = '0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, DIGW'(c - 8'h30)};
        else if (hm && c >= 8'h61 && c <= 8'h66)
            r = {1'b1, DIGW'(c - 8'h57)};
        else if (hm && c >= 8'h41 && c <= 8'h46)
            r = {1'b1, DIGW'(c - 8'h37)};
        return r;
    endfunction

    // Base for the current character: live input on the start cycle, latched afterwards.
    always_comb begin
        {dig_ok, dig_val} = decode(ch, (state_q == IDLE) ? hex : hex_q);
    end

    // Accumulator scaled by the latched base, wrapping modulo 2^DSZ.
    always_comb begin
        acc_mul = hex_q ? (acc_q << 4) : (acc_q * DSZ'(10));
    end

    // Read-only bus: address is tib while idle, the running pointer otherwise.
    assign mb_if.ai = (state_q == IDLE) ? tib : addr_q;
    assign mb_if.we = 1'b0;
    assign mb_if.vi = 8'h00;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        vo_d    = vo_q;
        neg_d   = neg_q;
        hex_d   = hex_q;
        term_d  = term_q;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    hex_d   = hex;
                    neg_d   = 1'b0;
                    acc_d   = '0;
                    term_d  = 1'b0;
                    addr_d  = tib + ASZ'(1);
                    state_d = CONV;
                    if (ch == 8'h2D)
                        neg_d = 1'b1;
                    else if (dig_ok)
                        acc_d = DSZ'(dig_val);
                    else
                        term_d = 1'b1;
                end
            end
            CONV: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (term_q || !dig_ok) begin
                    vo_d    = neg_q ? (DSZ'(0) - acc_q) : acc_q;
                    state_d = DONE;
                end else begin
                    acc_d  = acc_mul + DSZ'(dig_val);
                    addr_d = addr_q + ASZ'(1);
                end
            end
            DONE: begin
                if (!en)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        bsy_d = (state_d == CONV);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            acc_q   <= '0;
            vo_q    <= '0;
            neg_q   <= 1'b0;
            hex_q   <= 1'b0;
            term_q  <= 1'b0;
            bsy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            vo_q    <= vo_d;
            neg_q   <= neg_d;
            hex_q   <= hex_d;
            term_q  <= term_d;
            bsy_q   <= bsy_d;
        end
    end

    assign bsy = bsy_q;
    assign vo  = vo_q;
endmodule

// File: tb/tb_atoier.sv
// Bench for atoier: byte memory model on the bus, expected results queued at start.
module tb_atoier;
    localparam int unsigned ASZ = 17;
    localparam int unsigned DSZ = 32;

    logic           clk;
    logic           rst;
    logic           en;
    logic           hex;
    logic [ASZ-1:0] tib;
    logic [7:0]     ch;
    logic           bsy;
    logic [DSZ-1:0] vo;

    mb8_io #(.ASZ(ASZ)) mb ();

    atoier #(.ASZ(ASZ), .DSZ(DSZ)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .hex  (hex),
        .tib  (tib),
        .ch   (ch),
        .mb_if(mb),
        .bsy  (bsy),
        .vo   (vo)
    );

    logic [7:0]     mem [0:(1<<ASZ)-1];
    logic [DSZ-1:0] exp_q[$];
    logic [DSZ-1:0] model_vo;
    int             total;
    int             bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory reads on the falling edge, as the RAM does.
    always @(negedge clk) mb.vo <= mem[mb.ai];
    assign ch = mb.vo;

    task automatic load(input logic [ASZ-1:0] addr, input string s);
        for (int i = 0; i < s.len(); i++)
            mem[addr + ASZ'(i)] = s[i];
        mem[addr + ASZ'(s.len())] = 8'h00;
    endtask

    // Runs one conversion; checks busy at edge 1, end edge and result.
    task automatic run_conv(input string name, input logic [ASZ-1:0] addr, input string s,
                            input logic hx, input logic [DSZ-1:0] expv, input int exp_edges);
        int edges;
        logic [DSZ-1:0] e;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        load(addr, s);
        tib = addr;
        hex = hx;
        en  = 1'b1;
        exp_q.push_back(expv);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                total++;
                if (bsy !== 1'b1 || vo !== model_vo) begin
                    bad++;
                    $display("FAIL %s edge1: bsy=%b vo=%h required bsy=1 vo=%h", name, bsy, vo, model_vo);
                end
            end
            if (bsy === 1'b0) begin
                edges = k;
                break;
            end
        end
        total++;
        if (edges != exp_edges) begin
            bad++;
            $display("FAIL %s latency: edges=%0d required %0d", name, edges, exp_edges);
        end
        e = exp_q.pop_front();
        total++;
        if (vo !== e) begin
            bad++;
            $display("FAIL %s result: vo=%h required %h", name, vo, e);
        end
        model_vo = e;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; hex = 1'b0; tib = '0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bsy !== 1'b0 || vo !== '0 || mb.we !== 1'b0 || mb.vi !== 8'h00) begin
            bad++;
            $display("FAIL reset: bsy=%b vo=%h we=%b vi=%h required 0 0 0 0", bsy, vo, mb.we, mb.vi);
        end
        model_vo = '0;
        rst = 1'b1;
    endtask

    task automatic test_convert;
        run_conv("hex_neg",   ASZ'(0),     "-7f8",      1'b1, 32'hFFFFF808, 5);
        run_conv("dec_123",   ASZ'(16),    "123",       1'b0, 32'h0000007B, 4);
        run_conv("dec_neg42", ASZ'(32),    "-42",       1'b0, 32'hFFFFFFD6, 4);
        run_conv("hex_space", ASZ'(48),    "FF a",      1'b1, 32'h000000FF, 3);
        run_conv("dec_x",     ASZ'(64),    "12x",       1'b0, 32'd12,       3);
        run_conv("empty",     ASZ'(80),    "",          1'b0, 32'd0,        2);
        run_conv("lone_neg",  ASZ'(96),    "-",         1'b1, 32'd0,        2);
        run_conv("hex_wrap",  ASZ'(112),   "123456789", 1'b1, 32'h23456789, 10);
        run_conv("dec_alpha", ASZ'(128),   "a5",        1'b0, 32'd0,        2);
        run_conv("hex_mixed", ASZ'(144),   "-aB",       1'b1, 32'hFFFFFF55, 4);
        run_conv("addr_wrap", ASZ'(17'h1FFFE), "12",    1'b0, 32'd12,       3);
    endtask

    task automatic test_abort;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        load(ASZ'(200), "98765");
        tib = ASZ'(200); hex = 1'b0; en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (bsy !== 1'b0 || vo !== model_vo) begin
                bad++;
                $display("FAIL abort: bsy=%b vo=%h required 0 %h", bsy, vo, model_vo);
            end
        end
    endtask

    task automatic test_back_to_back;
        run_conv("first", ASZ'(300), "77", 1'b0, 32'd77, 3);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (bsy !== 1'b0 || vo !== model_vo) begin
                bad++;
                $display("FAIL hold: bsy=%b vo=%h required 0 %h", bsy, vo, model_vo);
            end
        end
        run_conv("second", ASZ'(400), "-1A", 1'b1, 32'hFFFFFFE6, 4);
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        load(ASZ'(500), "123456789");
        tib = ASZ'(500); hex = 1'b0; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (bsy !== 1'b0 || vo !== '0) begin
            bad++;
            $display("FAIL reset_mid: bsy=%b vo=%h required 0 0", bsy, vo);
        end
        model_vo = '0;
        en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bsy !== 1'b0 || vo !== '0) begin
            bad++;
            $display("FAIL no_restart: bsy=%b vo=%h required 0 0", bsy, vo);
        end
        run_conv("after_reset", ASZ'(600), "-5", 1'b0, 32'hFFFFFFFB, 3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_convert();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
